// File: rtl/axle_pkg.sv
// Shared definitions for the axle counter.
// Holds the per-channel wheel FSM state encoding (3 bits) and the default
// debounce length and axle-count width used by the top level.
package axle_pkg;

    localparam int STATE_W      = 3;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        A1   = 3'd1,
        A2   = 3'd2,
        A3   = 3'd3,
        B1   = 3'd4,
        B2   = 3'd5,
        B3   = 3'd6,
        ERR  = 3'd7
    } state_t;

endpackage

// File: rtl/axle_counter_multi_if.sv
// Bundle of the per-channel sensor inputs and detector outputs.
// Ports (all vectors indexed by channel):
//   a, b, clr        raw sensors and synchronous count clear (toward the DUT)
//   a2b, b2a, err    one-cycle event pulses
//   count            NUM_CH*CNT_W packed axle counts, channel i at [i*CNT_W +: CNT_W]
//   occupied         per-channel count != 0; any_occupied is their OR
//   dbg_state        per-channel FSM state, channel i at [i*3 +: 3]
// master drives the sensors (environment side); slave is the detector.
interface axle_counter_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4
);
    logic [NUM_CH-1:0]       a;
    logic [NUM_CH-1:0]       b;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       a2b;
    logic [NUM_CH-1:0]       b2a;
    logic [NUM_CH-1:0]       err;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       occupied;
    logic                    any_occupied;
    logic [NUM_CH*3-1:0]     dbg_state;

    modport master (
        output a, b, clr,
        input  a2b, b2a, err, count, occupied, any_occupied, dbg_state
    );

    modport slave (
        input  a, b, clr,
        output a2b, b2a, err, count, occupied, any_occupied, dbg_state
    );
endinterface

// File: rtl/wheel_dir_channel.sv
// One track channel: 2-FF synchroniser and debounce on each sensor, then the
// wheel-sequence FSM on the filtered pair {fa, fb}.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   a, b                raw sensors (asynchronous to Clk)
//   a2b, b2a, err       registered one-cycle pulses
//   fire_a2b, fire_b2a  combinational completion, valid the cycle before the
//                       matching pulse; lets the top update its count on the
//                       same edge that registers the pulse
//   state               current FSM state
module wheel_dir_channel
    import axle_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   a,
    input  logic   b,
    output logic   a2b,
    output logic   b2a,
    output logic   err,
    output logic   fire_a2b,
    output logic   fire_b2a,
    output state_t state
);

    localparam int DCW = $clog2(DEBOUNCE + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE - 1);

    // bit 1 = sensor a, bit 0 = sensor b
    logic [1:0]          ff1;
    logic [1:0]          ff2;
    logic [1:0]          filt;
    logic [1:0][DCW-1:0] db_cnt;

    state_t state_next;
    logic   enter_err;

    // Filtered value follows the synchronised one only after DEBOUNCE
    // consecutive mismatching samples; any agreeing sample restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ff1    <= '0;
            ff2    <= '0;
            filt   <= '0;
            db_cnt <= '0;
        end else begin
            ff1 <= {a, b};
            ff2 <= ff1;
            for (int i = 0; i < 2; i++) begin
                if (ff2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= ff2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DCW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        fire_a2b   = 1'b0;
        fire_b2a   = 1'b0;
        case (state)
            IDLE: case (filt)
                2'b10: state_next = A1;
                2'b01: state_next = B1;
                2'b11: state_next = ERR;
                default: ;
            endcase
            A1: case (filt)
                2'b11: state_next = A2;
                2'b00: state_next = IDLE;
                2'b01: state_next = ERR;
                default: ;
            endcase
            A2: case (filt)
                2'b01: state_next = A3;
                2'b10: state_next = A1;
                2'b00: state_next = ERR;
                default: ;
            endcase
            A3: case (filt)
                2'b00: begin
                    state_next = IDLE;
                    fire_a2b   = 1'b1;
                end
                2'b11: state_next = A2;
                2'b10: state_next = ERR;
                default: ;
            endcase
            B1: case (filt)
                2'b11: state_next = B2;
                2'b00: state_next = IDLE;
                2'b10: state_next = ERR;
                default: ;
            endcase
            B2: case (filt)
                2'b10: state_next = B3;
                2'b01: state_next = B1;
                2'b00: state_next = ERR;
                default: ;
            endcase
            B3: case (filt)
                2'b00: begin
                    state_next = IDLE;
                    fire_b2a   = 1'b1;
                end
                2'b11: state_next = B2;
                2'b01: state_next = ERR;
                default: ;
            endcase
            ERR: if (filt == 2'b00) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // err marks entry only, not residence in ERR
        enter_err = (state_next == ERR) && (state != ERR);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a2b   <= 1'b0;
            b2a   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            a2b   <= fire_a2b;
            b2a   <= fire_b2a;
            err   <= enter_err;
        end
    end

endmodule

// File: rtl/axle_counter_multi.sv
// Multi-channel wheel-direction detector and axle counter.
// Ports:
//   Clk, Reset  clock, asynchronous active-high reset
//   bus         slave side of axle_counter_multi_if (sensors, clr, pulses,
//               counts, occupancy, FSM debug state); its NUM_CH and CNT_W
//               must match this module's parameters
// Each channel's count saturates at both ends: overflow and underflow hold
// the value and raise err, while the direction pulse is still reported.
// clr wins over a same-cycle count change and suppresses the count err.
module axle_counter_multi
    import axle_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               Clk,
    input  logic               Reset,
    axle_counter_multi_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] ch_a2b;
    logic [NUM_CH-1:0] ch_b2a;
    logic [NUM_CH-1:0] ch_err;
    logic [NUM_CH-1:0] fire_a2b;
    logic [NUM_CH-1:0] fire_b2a;
    logic [NUM_CH-1:0] cnt_err;
    logic [NUM_CH-1:0] occ;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    state_t            ch_state [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wheel_dir_channel #(
            .DEBOUNCE(DEBOUNCE)
        ) u_ch (
            .Clk      (Clk),
            .Reset    (Reset),
            .a        (bus.a[g]),
            .b        (bus.b[g]),
            .a2b      (ch_a2b[g]),
            .b2a      (ch_b2a[g]),
            .err      (ch_err[g]),
            .fire_a2b (fire_a2b[g]),
            .fire_b2a (fire_b2a[g]),
            .state    (ch_state[g])
        );

        // Updated on the same edge that registers the channel's pulse, so
        // count and pulse become visible together.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                cnt_q[g]   <= '0;
                cnt_err[g] <= 1'b0;
            end else begin
                cnt_err[g] <= 1'b0;
                if (bus.clr[g]) begin
                    cnt_q[g] <= '0;
                end else if (fire_a2b[g]) begin
                    if (cnt_q[g] == CNT_MAX) cnt_err[g] <= 1'b1;
                    else                     cnt_q[g]   <= cnt_q[g] + CNT_W'(1);
                end else if (fire_b2a[g]) begin
                    if (cnt_q[g] == '0) cnt_err[g] <= 1'b1;
                    else                cnt_q[g]   <= cnt_q[g] - CNT_W'(1);
                end
            end
        end

        assign occ[g]                     = |cnt_q[g];
        assign bus.count[g*CNT_W +: CNT_W] = cnt_q[g];
        assign bus.dbg_state[g*3 +: 3]     = ch_state[g];
    end

    // FSM err and count err cannot coincide: count errors only follow a
    // completion, which never enters ERR.
    assign bus.a2b          = ch_a2b;
    assign bus.b2a          = ch_b2a;
    assign bus.err          = ch_err | cnt_err;
    assign bus.occupied     = occ;
    assign bus.any_occupied = |occ;

endmodule

// File: doc/axle_counter_multi.md
# axle_counter_multi

Multi-channel wheel-direction detector and axle counter for the level-crossing controller. Each channel takes one pair of track sensors (a, b), filters them, tracks the a→b or b→a wheel sequence with a per-channel state machine, and emits one-cycle direction pulses. A saturating axle count per channel drives an occupancy flag, which feeds the gate/barrier controller.

## Interface
- NUM_CH, default 2: number of independent sensor pairs (tracks); must be ≥1.
- DEBOUNCE, default 4: consecutive stable synchronised samples required before a filtered sensor changes; must be ≥1.
- CNT_W, default 4: axle-count width per channel.

Ports:
- Clk  in  1  single clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- a  in  NUM_CH  raw sensor A per channel (asynchronous to Clk).
- b  in  NUM_CH  raw sensor B per channel (asynchronous to Clk).
- clr  in  NUM_CH  synchronous per-channel count clear.
- a2b  out  NUM_CH  one-cycle pulse: wheel completed a→b.
- b2a  out  NUM_CH  one-cycle pulse: wheel completed b→a.
- err  out  NUM_CH  one-cycle pulse: illegal sequence, count overflow or count underflow.
- count  out  NUM_CH*CNT_W  axle count; channel i at bits [i*CNT_W +: CNT_W].
- occupied  out  NUM_CH  count of the channel ≠ 0.
- any_occupied  out  1  OR of occupied.

## Operation
- Per sensor: 2-FF synchroniser, then debounce. Filtered value f updates to the synchronised value s once s≠f for DEBOUNCE consecutive cycles. The counter clears whenever s==f.
- Per-channel FSM on filtered (fa,fb). Any input not listed holds the state.
  - IDLE: 10→A1; 01→B1; 11→ERR.
  - A1: 11→A2; 00→IDLE (aborted, silent); 01→ERR.
  - A2: 01→A3; 10→A1; 00→ERR.
  - A3: 00→IDLE with a2b; 11→A2; 10→ERR.
  - B1: 11→B2; 00→IDLE (silent); 10→ERR.
  - B2: 10→B3; 01→B1; 00→ERR.
  - B3: 00→IDLE with b2a; 11→B2; 01→ERR.
  - ERR: 00→IDLE; anything else holds.
- err pulses once, on entry to ERR only.
- Count update, per channel: a2b increments, b2a decrements.
  - Increment at 2^CNT_W−1 holds the value and pulses err (overflow).
  - Decrement at 0 holds 0 and pulses err (underflow).
  - The direction pulse still asserts in both cases.
- clr has priority over a same-cycle increment or decrement: count becomes 0. The direction pulse still asserts; no err is raised.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset values:
  - a2b = b2a = err = 0.
  - count = 0, occupied = 0, any_occupied = 0.
  - FSM state = IDLE.
  - Synchroniser and filtered values = 0; debounce counters = 0.
- Pipeline, with edge 0 the first edge that samples a raw change:
  - ff1 at edge 0, ff2 at edge 1.
  - Filtered value at edge 1+DEBOUNCE.
  - FSM state, pulse and count registered at edge 2+DEBOUNCE.
  - Pulses are visible for exactly the one cycle following that edge.
- occupied and any_occupied are combinational from the registered count. They change in the same cycle as count.
- Raw glitches shorter than DEBOUNCE cycles (after sync) produce no filtered change.
- Reset mid-sequence aborts the sequence: no pulse is issued, and the count is lost.
- An A3→IDLE completion followed immediately by 10 proceeds IDLE→A1 on the next filtered change. No dead cycle is required.

## Structure
- Shared package axle_pkg holds:
  - the state encoding localparams (IDLE, A1, A2, A3, B1, B2, B3, ERR; 3 bits);
  - the default DEBOUNCE and CNT_W values.
- Sub-module wheel_dir_channel holds one channel's logic: synchroniser, 2× debounce, FSM, and registered a2b/b2a/err pulses.
- Top level:
  - generates NUM_CH instances of wheel_dir_channel;
  - holds the per-channel saturating counters, clr handling and occupancy reduction.

## Test plan
All scenarios use NUM_CH=2, DEBOUNCE=4, CNT_W=4.
- Ch0 forward pass: ab = 00→10→11→01→00, 10 cycles per step → a2b[0] high 1 cycle, exactly 6 edges after 00 first sampled; count[0]=1; occupied=01; any_occupied=1.
- Ch0 reverse pass (01→11→10→00) after the forward pass → b2a[0] pulses; count[0]=0; occupied[0]=0. Partial entry 10→00 → no pulse, no err.
- Illegal jump 00→11 on ch1 → err[1] pulses once; FSM waits for 00; a following legal forward pass gives a2b[1] and count[1]=1.
- Saturation and underflow:
  - 16 forward passes on ch0 → count[0]=15, with err[0] pulsing on the 16th.
  - b2a on ch1 at count 0 → count stays 0 and err[1] pulses.
- 3-cycle glitch on a[0] → no state change. clr[0] asserted in the same cycle as an a2b completion → count[0]=0 and no err. Reset asserted mid-sequence → all outputs 0 immediately (asynchronous).
